// File: rtl/counter_sequencer.sv
// Command sequencer: queues {dir, len} commands in a 2-entry FIFO and steps a 3-bit up/down counter.
// Optional SEQ_SAT_GUARD_EN aborts a run before the driven counter would wrap.
module counter_sequencer #(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             pause,
  input  logic [2:0]       cnt_value,
  output logic             cnt_en,
  output logic             up_down,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] steps_left,
  output logic             sat
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic             dir;
    logic [LEN_W-1:0] len;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] steps_nxt;
  logic             up_down_nxt;
  logic             done_nxt;
  logic             sat_nxt;
  logic             sat_hit;

  cmd_t             fifo_mem [DEPTH];
  cmd_t             head;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  // Command FIFO: no bypass, so a freshly pushed command is seen by IDLE one cycle later
  assign fifo_full  = (fifo_cnt == CNT_W'(DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign cmd_ready  = !fifo_full && !rst;
  assign push       = cmd_valid && cmd_ready;
  assign head       = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= cmd_t'{dir: cmd_dir, len: cmd_len};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= !wr_ptr;
      end
      if (pop) begin
        rd_ptr <= !rd_ptr;
      end
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + CNT_W'(1);
      end else if (pop && !push) begin
        fifo_cnt <= fifo_cnt - CNT_W'(1);
      end
    end
  end

`ifdef SEQ_SAT_GUARD_EN
  // Stop before the counter would wrap past its end in the active direction
  assign sat_hit = up_down ? (cnt_value == 3'd7) : (cnt_value == 3'd0);
`else
  logic unused_cnt_value;
  assign unused_cnt_value = ^cnt_value;
  assign sat_hit          = 1'b0;
`endif

  // Next-state, FIFO pop and combinational strobes
  always_comb begin
    state_nxt   = state;
    steps_nxt   = steps_left;
    up_down_nxt = up_down;
    done_nxt    = 1'b0;
    sat_nxt     = 1'b0;
    pop         = 1'b0;
    cnt_en      = 1'b0;
    busy        = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          up_down_nxt = head.dir;
          steps_nxt   = head.len;
          if (head.len == '0) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        busy = !rst;
        if (sat_hit) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
          sat_nxt   = 1'b1;
        end else if (pause) begin
          state_nxt = S_PAUSE;
        end else begin
          cnt_en    = !rst;
          steps_nxt = steps_left - LEN_W'(1);
          if (steps_left == LEN_W'(1)) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end
        end
      end
      S_PAUSE: begin
        busy = !rst;
        if (!pause) begin
          state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      steps_left <= '0;
      up_down    <= 1'b0;
      done       <= 1'b0;
      sat        <= 1'b0;
    end else begin
      state      <= state_nxt;
      steps_left <= steps_nxt;
      up_down    <= up_down_nxt;
      done       <= done_nxt;
      sat        <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed scenarios, then randomized commands scored
// per command against an arithmetic model (follows SEQ_SAT_GUARD_EN when defined).
module tb_counter_sequencer;

  localparam int unsigned LEN_W = 4;
  localparam int unsigned N_RAND = 24;
`ifdef SEQ_SAT_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    logic             dir;
    logic [LEN_W-1:0] len;
  } cmd_t;

  typedef struct {
    int               en;
    logic             dir;
    logic             sat;
    logic [LEN_W-1:0] sl;
    bit               dir_ok;
  } obs_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [LEN_W-1:0] cmd_len;
  logic             pause;
  logic [2:0]       cnt_value = 3'd0;
  logic             cnt_en;
  logic             up_down;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] steps_left;
  logic             sat;

  logic             cnt_load = 1'b0;
  logic [2:0]       cnt_load_val = 3'd0;

  int tests = 0;
  int fails = 0;

  obs_t obs_q[$];
  cmd_t cmd_q[$];
  int   mon_en = 0;
  bit   mon_dir_ok = 1'b1;
  logic mon_dir = 1'b0;

  always #5 clk = ~clk;

  counter_sequencer #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_len   (cmd_len),
    .pause     (pause),
    .cnt_value (cnt_value),
    .cnt_en    (cnt_en),
    .up_down   (up_down),
    .busy      (busy),
    .done      (done),
    .steps_left(steps_left),
    .sat       (sat)
  );

  // The driven 3-bit up/down counter
  always @(posedge clk) begin
    if (cnt_load) cnt_value <= cnt_load_val;
    else if (cnt_en) cnt_value <= up_down ? cnt_value + 3'd1 : cnt_value - 3'd1;
  end

  // Per-command observation: enabled steps, direction and flags at the done pulse
  always @(negedge clk) begin
    if (rst) begin
      mon_en     = 0;
      mon_dir_ok = 1'b1;
    end else begin
      if (cnt_en) begin
        if (mon_en > 0 && up_down !== mon_dir) mon_dir_ok = 1'b0;
        mon_dir = up_down;
        mon_en++;
      end
      if (done) begin
        obs_q.push_back('{mon_en, up_down, sat, steps_left, mon_dir_ok});
        mon_en     = 0;
        mon_dir_ok = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic offer(input logic d, input logic [LEN_W-1:0] l);
    next_cyc();
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_len   = l;
    at_neg();
  endtask

  initial begin
    int   en_n;
    bit   got;
    int   cyc;
    int   sent;
    bit   acc;
    int   mc;
    int   room;
    int   steps;
    bit   esat;
    int   exp_en   [32];
    int   exp_dir  [32];
    int   exp_done [32];
    int   t;
    logic d2 [4];
    int   l2 [4];
    int   room6;
    int   steps6;

    rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_len = '0; pause = 1'b0;

    // Reset values and strobes held low while in reset
    next_cyc();
    at_neg();
    chk("rst_cnt_en", 32'(cnt_en), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_ready", 32'(cmd_ready), 32'(0));
    chk("rst_steps", 32'(steps_left), 32'(0));
    chk("rst_up_down", 32'(up_down), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_sat", 32'(sat), 32'(0));
    next_cyc();
    rst = 1'b0;
    at_neg();
    chk("idle_ready", 32'(cmd_ready), 32'(1));

    // Scenario 1: up by 5
    offer(1'b1, LEN_W'(5));
    chk("s1_accept", 32'(cmd_ready), 32'(1));
    next_cyc(); cmd_valid = 1'b0; at_neg();
    chk("s1_no_bypass", 32'(cnt_en), 32'(0));
    for (int i = 0; i < 5; i++) begin
      next_cyc(); at_neg();
      chk("s1_en", 32'(cnt_en), 32'(1));
      chk("s1_steps", 32'(steps_left), 32'(5 - i));
      chk("s1_dir", 32'(up_down), 32'(1));
      chk("s1_busy", 32'(busy), 32'(1));
    end
    next_cyc(); at_neg();
    chk("s1_done", 32'(done), 32'(1));
    chk("s1_done_en", 32'(cnt_en), 32'(0));
    chk("s1_done_steps", 32'(steps_left), 32'(0));
    chk("s1_done_busy", 32'(busy), 32'(0));
    next_cyc(); at_neg();
    chk("s1_done_once", 32'(done), 32'(0));
    chk("s1_busy_after", 32'(busy), 32'(0));
    chk("s1_dir_hold", 32'(up_down), 32'(1));

    // Scenario 2: three back-to-back pushes plus a refused fourth
    d2[0] = 1'b0; l2[0] = 2;
    d2[1] = 1'b1; l2[1] = 3;
    d2[2] = 1'b0; l2[2] = 1;
    d2[3] = 1'b1; l2[3] = 7;
    for (int i = 0; i < 32; i++) begin exp_en[i] = 0; exp_dir[i] = 0; exp_done[i] = 0; end
    t = 2;
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < l2[k]; s++) begin exp_en[t] = 1; exp_dir[t] = int'(d2[k]); t++; end
      exp_done[t] = 1;
      t += 2;
    end
    for (int i = 0; i < t; i++) begin
      next_cyc();
      cmd_valid = (i < 4);
      if (i < 4) begin cmd_dir = d2[i]; cmd_len = LEN_W'(l2[i]); end
      at_neg();
      if (i < 3) chk("s2_accept", 32'(cmd_ready), 32'(1));
      if (i == 3) chk("s2_full", 32'(cmd_ready), 32'(0));
      chk("s2_en", 32'(cnt_en), 32'(exp_en[i]));
      if (exp_en[i] == 1) chk("s2_dir", 32'(up_down), 32'(exp_dir[i]));
      chk("s2_done", 32'(done), 32'(exp_done[i]));
    end
    next_cyc(); at_neg();
    chk("s2_drained", 32'(busy), 32'(0));

    // Scenario 3: down by 4 with pause for 3 cycles after 2 steps
    offer(1'b0, LEN_W'(4));
    chk("s3_accept", 32'(cmd_ready), 32'(1));
    en_n = 0;
    for (int i = 1; i <= 10; i++) begin
      next_cyc();
      cmd_valid = 1'b0;
      pause = (i >= 4 && i <= 6);
      at_neg();
      if (cnt_en) begin
        en_n++;
        chk("s3_dir", 32'(up_down), 32'(0));
      end
      if (i >= 4 && i <= 7) begin
        chk("s3_frozen", 32'(steps_left), 32'(2));
        chk("s3_paused_en", 32'(cnt_en), 32'(0));
        chk("s3_paused_busy", 32'(busy), 32'(1));
      end
      chk("s3_done", 32'(done), 32'(i == 10));
    end
    chk("s3_en_total", 32'(en_n), 32'(4));
    pause = 1'b0;

    // Scenario 4: zero-length command, pause held in IDLE and DONE
    offer(1'b1, LEN_W'(0));
    chk("s4_accept", 32'(cmd_ready), 32'(1));
    next_cyc(); cmd_valid = 1'b0; pause = 1'b1; at_neg();
    chk("s4_idle_en", 32'(cnt_en), 32'(0));
    chk("s4_idle_done", 32'(done), 32'(0));
    next_cyc(); at_neg();
    chk("s4_done", 32'(done), 32'(1));
    chk("s4_en", 32'(cnt_en), 32'(0));
    chk("s4_dir", 32'(up_down), 32'(1));
    chk("s4_sat", 32'(sat), 32'(0));
    next_cyc(); pause = 1'b0; at_neg();
    chk("s4_done_once", 32'(done), 32'(0));
    chk("s4_busy", 32'(busy), 32'(0));

    // Scenario 5: reset during RUN with one command queued
    offer(1'b1, LEN_W'(6));
    chk("s5_accept0", 32'(cmd_ready), 32'(1));
    offer(1'b0, LEN_W'(3));
    chk("s5_accept1", 32'(cmd_ready), 32'(1));
    next_cyc(); cmd_valid = 1'b0; at_neg();
    chk("s5_running", 32'(cnt_en), 32'(1));
    next_cyc(); rst = 1'b1; at_neg();
    chk("s5_rst_en", 32'(cnt_en), 32'(0));
    chk("s5_rst_busy", 32'(busy), 32'(0));
    chk("s5_rst_ready", 32'(cmd_ready), 32'(0));
    next_cyc(); rst = 1'b0; at_neg();
    chk("s5_idle_en", 32'(cnt_en), 32'(0));
    chk("s5_idle_steps", 32'(steps_left), 32'(0));
    chk("s5_idle_dir", 32'(up_down), 32'(0));
    chk("s5_idle_ready", 32'(cmd_ready), 32'(1));
    for (int i = 0; i < 4; i++) begin
      next_cyc(); at_neg();
      chk("s5_no_done", 32'(done), 32'(0));
      chk("s5_discarded", 32'(busy), 32'(0));
    end

    // Scenario 6: counter at 5, up by 6
    next_cyc(); cnt_load = 1'b1; cnt_load_val = 3'd5;
    next_cyc(); cnt_load = 1'b0;
    room6  = 7 - 5;
    steps6 = (GUARD && 6 > room6) ? room6 : 6;
    offer(1'b1, LEN_W'(6));
    chk("s6_accept", 32'(cmd_ready), 32'(1));
    got = 1'b0; en_n = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      next_cyc(); cmd_valid = 1'b0; at_neg();
      if (cnt_en) en_n++;
      if (done) begin
        got = 1'b1;
        chk("s6_steps_run", 32'(en_n), 32'(steps6));
        chk("s6_sat", 32'(sat), 32'(GUARD));
        chk("s6_steps_left", 32'(steps_left), 32'(6 - steps6));
      end
    end
    chk("s6_done_seen", 32'(got), 32'(1));
    next_cyc(); at_neg();
    chk("s6_sat_once", 32'(sat), 32'(0));

    // Randomized commands and pauses
    next_cyc(); cnt_load = 1'b1; cnt_load_val = 3'd3;
    next_cyc(); cnt_load = 1'b0;
    obs_q.delete();
    sent = 0; cyc = 0; acc = 1'b0;
    while ((sent < int'(N_RAND) || obs_q.size() < int'(N_RAND)) && cyc < 4000) begin
      next_cyc();
      cyc++;
      if (acc) cmd_valid = 1'b0;
      if (!cmd_valid && sent < int'(N_RAND) && $urandom_range(0, 2) != 0) begin
        cmd_valid = 1'b1;
        cmd_dir   = 1'($urandom_range(0, 1));
        cmd_len   = LEN_W'($urandom_range(0, 9));
      end
      pause = ($urandom_range(0, 3) == 0);
      at_neg();
      acc = cmd_valid && cmd_ready;
      if (acc) begin
        cmd_q.push_back('{cmd_dir, cmd_len});
        sent++;
      end
    end
    cmd_valid = 1'b0;
    pause = 1'b0;
    chk("rand_completed", 32'(obs_q.size()), 32'(N_RAND));
    mc = 3;
    for (int k = 0; k < obs_q.size() && k < cmd_q.size(); k++) begin
      room  = cmd_q[k].dir ? 7 - mc : mc;
      esat  = GUARD && (int'(cmd_q[k].len) > room);
      steps = esat ? room : int'(cmd_q[k].len);
      mc    = (mc + (cmd_q[k].dir ? steps : -steps) + 16) % 8;
      chk("rand_steps", 32'(obs_q[k].en), 32'(steps));
      chk("rand_dir", 32'(obs_q[k].dir), 32'(cmd_q[k].dir));
      chk("rand_dir_steady", 32'(obs_q[k].dir_ok), 32'(1));
      chk("rand_sat", 32'(obs_q[k].sat), 32'(esat));
      chk("rand_steps_left", 32'(obs_q[k].sl), 32'(int'(cmd_q[k].len) - steps));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
